// File: rtl/axi_pmu_slave_if.sv
// AXI4-Lite bundle between the NoC bridge (master) and the PMU slave.
`timescale 1ns/1ps
interface axi_pmu_slave_if #(
  parameter int COUNTER_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH     = 64
);
  logic [AXI_ADDR_WIDTH-1:0]         S_AXI_AWADDR;
  logic [2:0]                        S_AXI_AWPROT;
  logic                              S_AXI_AWVALID;
  logic                              S_AXI_AWREADY;
  logic [COUNTER_DATA_WIDTH-1:0]     S_AXI_WDATA;
  logic [COUNTER_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
  logic                              S_AXI_WVALID;
  logic                              S_AXI_WREADY;
  logic [1:0]                        S_AXI_BRESP;
  logic                              S_AXI_BVALID;
  logic                              S_AXI_BREADY;
  logic [AXI_ADDR_WIDTH-1:0]         S_AXI_ARADDR;
  logic [2:0]                        S_AXI_ARPROT;
  logic                              S_AXI_ARVALID;
  logic                              S_AXI_ARREADY;
  logic [COUNTER_DATA_WIDTH-1:0]     S_AXI_RDATA;
  logic [1:0]                        S_AXI_RRESP;
  logic                              S_AXI_RVALID;
  logic                              S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/axi_pmu_slave.sv
// AXI4-Lite slave that converts each read/write into a 4-phase req/ack
// transfer towards the PMU counter bank. The bank acknowledges from its own
// clock domain, so both acknowledges are double-flopped before use. Only one
// transaction is open at a time; the bus is simply back-pressured meanwhile.
`timescale 1ns/1ps
module axi_pmu_slave #(
  parameter int COUNTER_DATA_WIDTH    = 64,
  parameter int COUNTER_ADDRESS_WIDTH = 16,
  parameter int AXI_ADDR_WIDTH        = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  axi_pmu_slave_if.slave                   s_axi,
  output logic                             counter_read_enable,
  input  logic                             counter_read_valid,
  output logic [COUNTER_ADDRESS_WIDTH-1:0] counter_read_address,
  input  logic [COUNTER_DATA_WIDTH-1:0]    counter_read_data,
  output logic                             counter_write_enable,
  input  logic                             counter_write_valid,
  output logic [COUNTER_ADDRESS_WIDTH-1:0] counter_write_address,
  output logic [COUNTER_DATA_WIDTH-1:0]    counter_write_data
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_REL  = 3'd2;
  localparam logic [2:0] WR_RESP = 3'd3;
  localparam logic [2:0] RD_REQ  = 3'd4;
  localparam logic [2:0] RD_REL  = 3'd5;
  localparam logic [2:0] RD_RESP = 3'd6;

  logic [2:0]                       state_q, state_d;
  logic                             awHeld_q, awHeld_d;
  logic                             wHeld_q, wHeld_d;
  logic [COUNTER_ADDRESS_WIDTH-1:0] wrAddr_q, wrAddr_d;
  logic [COUNTER_DATA_WIDTH-1:0]    wrData_q, wrData_d;
  logic [COUNTER_ADDRESS_WIDTH-1:0] rdAddr_q, rdAddr_d;
  logic [COUNTER_DATA_WIDTH-1:0]    rdData_q, rdData_d;
  logic                             wrEn_q, wrEn_d;
  logic                             rdEn_q, rdEn_d;
  logic                             bValid_q, bValid_d;
  logic                             rValid_q, rValid_d;
  logic [1:0]                       wrAckSync_q;
  logic [1:0]                       rdAckSync_q;

  logic wrAck;
  logic rdAck;
  logic idle;
  logic awReady;
  logic wReady;
  logic arReady;
  logic awHs;
  logic wHs;
  logic arHs;
  logic unusedInputs;

  // Protection bits, strobes and upper address bits carry no meaning for
  // the counter bank; every write is a full word.
  assign unusedInputs = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, s_axi.S_AXI_WSTRB,
                          s_axi.S_AXI_AWADDR, s_axi.S_AXI_ARADDR};

  assign wrAck = wrAckSync_q[1];
  assign rdAck = rdAckSync_q[1];
  assign idle  = (state_q == IDLE);

  // Ready is only offered from IDLE and never while reset is asserted.
  // A read is held off whenever any part of a write is pending or offered,
  // which gives writes priority when both arrive together.
  assign awReady = idle && !awHeld_q && !rst;
  assign wReady  = idle && !wHeld_q && !rst;
  assign arReady = idle && !awHeld_q && !wHeld_q && !s_axi.S_AXI_AWVALID &&
                   !s_axi.S_AXI_WVALID && !rst;

  assign awHs = awReady && s_axi.S_AXI_AWVALID;
  assign wHs  = wReady && s_axi.S_AXI_WVALID;
  assign arHs = arReady && s_axi.S_AXI_ARVALID;

  assign s_axi.S_AXI_AWREADY = awReady;
  assign s_axi.S_AXI_WREADY  = wReady;
  assign s_axi.S_AXI_ARREADY = arReady;
  assign s_axi.S_AXI_BVALID  = bValid_q;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_RVALID  = rValid_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;
  assign s_axi.S_AXI_RDATA   = rdData_q;

  assign counter_write_enable  = wrEn_q;
  assign counter_write_address = wrAddr_q;
  assign counter_write_data    = wrData_q;
  assign counter_read_enable   = rdEn_q;
  assign counter_read_address  = rdAddr_q;

  // Next-state logic: capture AW/W in any order, run the 4-phase handshake,
  // then hold the AXI response until the master accepts it.
  always_comb begin
    state_d  = state_q;
    awHeld_d = awHeld_q;
    wHeld_d  = wHeld_q;
    wrAddr_d = wrAddr_q;
    wrData_d = wrData_q;
    rdAddr_d = rdAddr_q;
    rdData_d = rdData_q;
    wrEn_d   = wrEn_q;
    rdEn_d   = rdEn_q;
    bValid_d = bValid_q;
    rValid_d = rValid_q;

    case (state_q)
      IDLE: begin
        if (awHs) begin
          awHeld_d = 1'b1;
          wrAddr_d = s_axi.S_AXI_AWADDR[COUNTER_ADDRESS_WIDTH-1:0];
        end
        if (wHs) begin
          wHeld_d  = 1'b1;
          wrData_d = s_axi.S_AXI_WDATA;
        end
        if ((awHeld_q || awHs) && (wHeld_q || wHs)) begin
          state_d = WR_REQ;
          wrEn_d  = 1'b1;
        end else if (arHs) begin
          rdAddr_d = s_axi.S_AXI_ARADDR[COUNTER_ADDRESS_WIDTH-1:0];
          state_d  = RD_REQ;
          rdEn_d   = 1'b1;
        end
      end
      WR_REQ: begin
        if (wrAck) begin
          wrEn_d  = 1'b0;
          state_d = WR_REL;
        end
      end
      WR_REL: begin
        if (!wrAck) begin
          bValid_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (s_axi.S_AXI_BREADY) begin
          bValid_d = 1'b0;
          awHeld_d = 1'b0;
          wHeld_d  = 1'b0;
          state_d  = IDLE;
        end
      end
      RD_REQ: begin
        if (rdAck) begin
          rdData_d = counter_read_data;
          rdEn_d   = 1'b0;
          state_d  = RD_REL;
        end
      end
      RD_REL: begin
        if (!rdAck) begin
          rValid_d = 1'b1;
          state_d  = RD_RESP;
        end
      end
      RD_RESP: begin
        if (s_axi.S_AXI_RREADY) begin
          rValid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        awHeld_d = 1'b0;
        wHeld_d  = 1'b0;
        wrEn_d   = 1'b0;
        rdEn_d   = 1'b0;
        bValid_d = 1'b0;
        rValid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset drops any open transaction immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      awHeld_q <= 1'b0;
      wHeld_q  <= 1'b0;
      wrAddr_q <= '0;
      wrData_q <= '0;
      rdAddr_q <= '0;
      rdData_q <= '0;
      wrEn_q   <= 1'b0;
      rdEn_q   <= 1'b0;
      bValid_q <= 1'b0;
      rValid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      awHeld_q <= awHeld_d;
      wHeld_q  <= wHeld_d;
      wrAddr_q <= wrAddr_d;
      wrData_q <= wrData_d;
      rdAddr_q <= rdAddr_d;
      rdData_q <= rdData_d;
      wrEn_q   <= wrEn_d;
      rdEn_q   <= rdEn_d;
      bValid_q <= bValid_d;
      rValid_q <= rValid_d;
    end
  end

  // Two-flop synchronisers for the acknowledges coming from the counter clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrAckSync_q <= 2'b00;
      rdAckSync_q <= 2'b00;
    end else begin
      wrAckSync_q <= {wrAckSync_q[0], counter_write_valid};
      rdAckSync_q <= {rdAckSync_q[0], counter_read_valid};
    end
  end

endmodule

// File: tb/tb_axi_pmu_slave.sv
// Self-checking bench for axi_pmu_slave: table of directed read/write vectors
// plus hand-written sequences for arbitration, reset and slow acknowledges.
`timescale 1ns/1ps
module tb_axi_pmu_slave;

  localparam int DW      = 64;
  localparam int CAW     = 16;
  localparam int AXW     = 64;
  localparam int TIMEOUT = 500;

  logic           clk = 1'b0;
  logic           cclk = 1'b0;
  logic           rst;
  logic           counter_read_enable;
  logic           counter_read_valid;
  logic [CAW-1:0] counter_read_address;
  logic [DW-1:0]  counter_read_data;
  logic           counter_write_enable;
  logic           counter_write_valid;
  logic [CAW-1:0] counter_write_address;
  logic [DW-1:0]  counter_write_data;

  int testsRun = 0;
  int testsFailed = 0;

  // bank model knobs and observations
  int             ackDelay = 3;
  int             relDelay = 2;
  logic [DW-1:0]  bankReadData = '0;
  logic [CAW-1:0] seenRdAddr = '0;
  logic [CAW-1:0] seenWrAddr = '0;
  logic [DW-1:0]  seenWrData = '0;
  realtime        rdRelTime = 0;
  realtime        rvalidTime = 0;

  // bus monitor observations
  int rBeats = 0;
  int bBeats = 0;
  int bothEnErr = 0;
  int seq = 0;
  int wrEnSeq = 0;
  int rdEnSeq = 0;
  logic prevWe = 1'b0;
  logic prevRe = 1'b0;

  typedef struct {
    bit          isWrite;
    logic [63:0] addr;
    logic [63:0] data;
    int          awDelay;
    int          wDelay;
    int          hold;
    logic [15:0] expAddr;
    logic [63:0] expData;
  } vec_t;

  vec_t vecs[6];

  axi_pmu_slave_if #(.COUNTER_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AXW)) axi();

  axi_pmu_slave #(
    .COUNTER_DATA_WIDTH(DW),
    .COUNTER_ADDRESS_WIDTH(CAW),
    .AXI_ADDR_WIDTH(AXW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axi(axi),
    .counter_read_enable(counter_read_enable),
    .counter_read_valid(counter_read_valid),
    .counter_read_address(counter_read_address),
    .counter_read_data(counter_read_data),
    .counter_write_enable(counter_write_enable),
    .counter_write_valid(counter_write_valid),
    .counter_write_address(counter_write_address),
    .counter_write_data(counter_write_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1.3;
    forever #3.5 cclk = ~cclk;
  end

  // Counter bank on its own clock: raises valid ackDelay cycles after the
  // request, drops it relDelay cycles after the request is released.
  initial begin
    int rdCnt;
    int wrCnt;
    rdCnt = 0;
    wrCnt = 0;
    counter_read_valid  = 1'b0;
    counter_write_valid = 1'b0;
    counter_read_data   = '0;
    forever begin
      @(posedge cclk);
      if (rst) begin
        rdCnt = 0;
        wrCnt = 0;
        counter_read_valid  = 1'b0;
        counter_write_valid = 1'b0;
      end else begin
        if (counter_read_enable && !counter_read_valid) begin
          rdCnt++;
          if (rdCnt >= ackDelay) begin
            counter_read_data  = bankReadData;
            seenRdAddr         = counter_read_address;
            counter_read_valid = 1'b1;
            rdCnt = 0;
          end
        end else if (!counter_read_enable && counter_read_valid) begin
          rdCnt++;
          if (rdCnt >= relDelay) begin
            counter_read_valid = 1'b0;
            rdRelTime = $realtime;
            rdCnt = 0;
          end
        end else begin
          rdCnt = 0;
        end
        if (counter_write_enable && !counter_write_valid) begin
          wrCnt++;
          if (wrCnt >= ackDelay) begin
            seenWrAddr = counter_write_address;
            seenWrData = counter_write_data;
            counter_write_valid = 1'b1;
            wrCnt = 0;
          end
        end else if (!counter_write_enable && counter_write_valid) begin
          wrCnt++;
          if (wrCnt >= relDelay) begin
            counter_write_valid = 1'b0;
            wrCnt = 0;
          end
        end else begin
          wrCnt = 0;
        end
      end
    end
  end

  // Beat counting and enable ordering, sampled mid-cycle.
  always @(negedge clk) begin
    #1;
    if (axi.S_AXI_RVALID && axi.S_AXI_RREADY) rBeats++;
    if (axi.S_AXI_BVALID && axi.S_AXI_BREADY) bBeats++;
    if (counter_read_enable && counter_write_enable) bothEnErr++;
    if (counter_write_enable && !prevWe) wrEnSeq = ++seq;
    if (counter_read_enable && !prevRe) rdEnSeq = ++seq;
    prevWe = counter_write_enable;
    prevRe = counter_read_enable;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyWrite(input logic [63:0] addr, input logic [63:0] data,
                            input int awDelay, input int wDelay, input int hold,
                            output logic [1:0] resp, output bit timedOut,
                            output bit protocolOk);
    bit awOk;
    bit wOk;
    bit bOk;
    awOk = 0;
    wOk = 0;
    bOk = 0;
    timedOut = 0;
    protocolOk = 1;
    resp = 2'b11;
    fork
      begin
        repeat (awDelay) @(negedge clk);
        axi.S_AXI_AWADDR  = addr;
        axi.S_AXI_AWVALID = 1'b1;
        for (int i = 0; i < TIMEOUT; i++) begin
          #1;
          if (axi.S_AXI_AWREADY) begin awOk = 1; break; end
          @(negedge clk);
        end
        @(negedge clk);
        axi.S_AXI_AWVALID = 1'b0;
      end
      begin
        repeat (wDelay) @(negedge clk);
        axi.S_AXI_WDATA  = data;
        axi.S_AXI_WVALID = 1'b1;
        for (int i = 0; i < TIMEOUT; i++) begin
          #1;
          if (axi.S_AXI_WREADY) begin wOk = 1; break; end
          @(negedge clk);
        end
        @(negedge clk);
        axi.S_AXI_WVALID = 1'b0;
      end
    join
    if (!(awOk && wOk)) begin
      timedOut = 1;
    end else begin
      for (int i = 0; i < TIMEOUT; i++) begin
        #1;
        if (axi.S_AXI_BVALID) begin bOk = 1; break; end
        @(negedge clk);
      end
      if (!bOk) begin
        timedOut = 1;
      end else begin
        resp = axi.S_AXI_BRESP;
        repeat (hold) begin
          @(negedge clk);
          #1;
          if (!axi.S_AXI_BVALID || axi.S_AXI_BRESP !== 2'b00 || axi.S_AXI_AWREADY ||
              axi.S_AXI_WREADY || axi.S_AXI_ARREADY)
            protocolOk = 0;
        end
        @(negedge clk);
        axi.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        axi.S_AXI_BREADY = 1'b0;
        #1;
        if (axi.S_AXI_BVALID) protocolOk = 0;
      end
    end
  endtask

  task automatic applyRead(input logic [63:0] addr, input int hold,
                           output logic [63:0] data, output logic [1:0] resp,
                           output bit timedOut, output bit protocolOk);
    bit arOk;
    bit rOk;
    arOk = 0;
    rOk = 0;
    timedOut = 0;
    protocolOk = 1;
    data = '1;
    resp = 2'b11;
    axi.S_AXI_ARADDR  = addr;
    axi.S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < TIMEOUT; i++) begin
      #1;
      if (axi.S_AXI_ARREADY) begin arOk = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    axi.S_AXI_ARVALID = 1'b0;
    if (!arOk) begin
      timedOut = 1;
    end else begin
      for (int i = 0; i < TIMEOUT; i++) begin
        #1;
        if (axi.S_AXI_RVALID) begin rOk = 1; break; end
        @(negedge clk);
      end
      if (!rOk) begin
        timedOut = 1;
      end else begin
        rvalidTime = $realtime;
        data = axi.S_AXI_RDATA;
        resp = axi.S_AXI_RRESP;
        repeat (hold) begin
          @(negedge clk);
          #1;
          if (!axi.S_AXI_RVALID || axi.S_AXI_RDATA !== data || axi.S_AXI_AWREADY ||
              axi.S_AXI_WREADY || axi.S_AXI_ARREADY)
            protocolOk = 0;
        end
        @(negedge clk);
        axi.S_AXI_RREADY = 1'b1;
        @(negedge clk);
        axi.S_AXI_RREADY = 1'b0;
        #1;
        if (axi.S_AXI_RVALID) protocolOk = 0;
      end
    end
  endtask

  initial begin
    logic [1:0]  resp;
    logic [63:0] rdata;
    bit          timedOut;
    bit          protocolOk;
    bit          enSeen;
    int          rBefore;
    int          bBefore;

    // inputs at rest, reset asserted
    rst = 1'b1;
    axi.S_AXI_AWADDR  = '0;
    axi.S_AXI_AWPROT  = 3'b000;
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA   = '0;
    axi.S_AXI_WSTRB   = '1;
    axi.S_AXI_WVALID  = 1'b0;
    axi.S_AXI_BREADY  = 1'b0;
    axi.S_AXI_ARADDR  = '0;
    axi.S_AXI_ARPROT  = 3'b000;
    axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY  = 1'b0;

    vecs[0] = '{1'b0, 64'h8, 64'h1234, 0, 0, 0, 16'h0008, 64'h1234};
    vecs[1] = '{1'b1, 64'h40, 64'hDEADBEEF, 0, 5, 0, 16'h0040, 64'hDEADBEEF};
    vecs[2] = '{1'b1, 64'hFFFF_0000_0001_2344, 64'hFFFF_FFFF_FFFF_FFFF, 3, 0, 0,
                16'h2344, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[3] = '{1'b0, 64'h1_0000_ABCD, 64'h8000_0000_0000_0001, 0, 0, 10,
                16'hABCD, 64'h8000_0000_0000_0001};
    vecs[4] = '{1'b1, 64'h0, 64'h0, 0, 0, 10, 16'h0000, 64'h0};
    vecs[5] = '{1'b0, 64'hFFFF, 64'hA5A5_5A5A_0F0F_F0F0, 0, 0, 0,
                16'hFFFF, 64'hA5A5_5A5A_0F0F_F0F0};

    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset AWREADY", 64'(axi.S_AXI_AWREADY), 64'h0);
    checkOutput("reset WREADY", 64'(axi.S_AXI_WREADY), 64'h0);
    checkOutput("reset ARREADY", 64'(axi.S_AXI_ARREADY), 64'h0);
    checkOutput("reset BVALID", 64'(axi.S_AXI_BVALID), 64'h0);
    checkOutput("reset RVALID", 64'(axi.S_AXI_RVALID), 64'h0);
    checkOutput("reset enables", 64'({counter_read_enable, counter_write_enable}), 64'h0);
    checkOutput("reset RDATA", axi.S_AXI_RDATA, 64'h0);
    checkOutput("reset write addr", 64'(counter_write_address), 64'h0);
    checkOutput("reset write data", counter_write_data, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("idle ARREADY", 64'(axi.S_AXI_ARREADY), 64'h1);
    checkOutput("idle AWREADY", 64'(axi.S_AXI_AWREADY), 64'h1);

    // table-driven single transactions
    for (int i = 0; i < 6; i++) begin
      ackDelay = 3;
      relDelay = 2;
      bankReadData = vecs[i].data;
      rBefore = rBeats;
      bBefore = bBeats;
      @(negedge clk);
      if (vecs[i].isWrite) begin
        applyWrite(vecs[i].addr, vecs[i].data, vecs[i].awDelay, vecs[i].wDelay,
                   vecs[i].hold, resp, timedOut, protocolOk);
        checkOutput($sformatf("vec%0d write timeout", i), 64'(timedOut), 64'h0);
        checkOutput($sformatf("vec%0d BRESP", i), 64'(resp), 64'h0);
        checkOutput($sformatf("vec%0d write addr", i), 64'(seenWrAddr), 64'(vecs[i].expAddr));
        checkOutput($sformatf("vec%0d write data", i), seenWrData, vecs[i].expData);
        checkOutput($sformatf("vec%0d B beats", i), 64'(bBeats - bBefore), 64'h1);
      end else begin
        applyRead(vecs[i].addr, vecs[i].hold, rdata, resp, timedOut, protocolOk);
        checkOutput($sformatf("vec%0d read timeout", i), 64'(timedOut), 64'h0);
        checkOutput($sformatf("vec%0d RRESP", i), 64'(resp), 64'h0);
        checkOutput($sformatf("vec%0d read addr", i), 64'(seenRdAddr), 64'(vecs[i].expAddr));
        checkOutput($sformatf("vec%0d RDATA", i), rdata, vecs[i].expData);
        checkOutput($sformatf("vec%0d R beats", i), 64'(rBeats - rBefore), 64'h1);
      end
      checkOutput($sformatf("vec%0d protocol/hold", i), 64'(protocolOk), 64'h1);
    end

    // AR together with AW+W: the write must be served first
    wrEnSeq = 0;
    rdEnSeq = 0;
    bankReadData = 64'h0BAD_CAFE;
    @(negedge clk);
    fork
      begin
        logic [1:0] wResp;
        bit wTo;
        bit wOk;
        applyWrite(64'h80, 64'h1111_2222, 0, 0, 0, wResp, wTo, wOk);
        checkOutput("prio write timeout", 64'(wTo), 64'h0);
        checkOutput("prio write addr", 64'(seenWrAddr), 64'h80);
      end
      begin
        logic [63:0] rData;
        logic [1:0] rResp;
        bit rTo;
        bit rOk;
        applyRead(64'h90, 0, rData, rResp, rTo, rOk);
        checkOutput("prio read timeout", 64'(rTo), 64'h0);
        checkOutput("prio RDATA", rData, 64'h0BAD_CAFE);
      end
    join
    checkOutput("prio write before read", 64'(wrEnSeq != 0 && rdEnSeq > wrEnSeq), 64'h1);

    // reset while a read request is outstanding
    ackDelay = 200;
    @(negedge clk);
    axi.S_AXI_ARADDR  = 64'h77;
    axi.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    axi.S_AXI_ARVALID = 1'b0;
    enSeen = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      #1;
      if (counter_read_enable) begin enSeen = 1; break; end
      @(negedge clk);
    end
    checkOutput("rst test enable raised", 64'(enSeen), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst drops read enable", 64'(counter_read_enable), 64'h0);
    checkOutput("rst read addr", 64'(counter_read_address), 64'h0);
    checkOutput("rst ARREADY", 64'(axi.S_AXI_ARREADY), 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ackDelay = 3;
    bankReadData = 64'h5555_0001;
    @(negedge clk);
    applyRead(64'h10, 0, rdata, resp, timedOut, protocolOk);
    checkOutput("post-rst read timeout", 64'(timedOut), 64'h0);
    checkOutput("post-rst RDATA", rdata, 64'h5555_0001);
    checkOutput("post-rst read addr", 64'(seenRdAddr), 64'h0010);

    // slow acknowledge: no response before the bank drops valid
    ackDelay = 20;
    relDelay = 15;
    bankReadData = 64'h00C0_FFEE;
    rdRelTime = 0;
    @(negedge clk);
    applyRead(64'h20, 0, rdata, resp, timedOut, protocolOk);
    checkOutput("slow read timeout", 64'(timedOut), 64'h0);
    checkOutput("slow RDATA", rdata, 64'h00C0_FFEE);
    checkOutput("slow RVALID after ack release", 64'(rdRelTime > 0 && rvalidTime > rdRelTime), 64'h1);

    checkOutput("enables never both high", 64'(bothEnErr), 64'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
